// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, two-entry skid buffer, flush and bubbles.
// Optional PIPE_STAGE_SKID_STATS_EN adds saturating stall/flush counters.
module pipe_stage_skid_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
`ifdef PIPE_STAGE_SKID_STATS_EN
    ,
    output logic [15:0]       o_stall_cnt,
    output logic [15:0]       o_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic               accept, emit;

    // Handshake outputs decode the state register only; no path from i_ready.
    assign o_ready = (state_q != StFull);
    assign o_valid = (state_q != StEmpty);
    assign o_data  = main_data_q;
    assign o_ctrl  = main_ctrl_q;

    assign accept = i_valid & o_ready;
    assign emit   = o_valid & i_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d     = StEmpty;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        state_d     = StBusy;
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                    end
                end
                StBusy: begin
                    if (accept && !emit) begin
                        state_d     = StFull;
                        skid_data_d = i_data;
                        skid_ctrl_d = i_ctrl;
                    end else if (accept && emit) begin
                        main_data_d = i_data;
                        main_ctrl_d = i_ctrl;
                    end else if (emit) begin
                        // Bubble: control goes to zero, data is left as-is.
                        state_d     = StEmpty;
                        main_ctrl_d = '0;
                    end
                end
                StFull: begin
                    if (emit) begin
                        state_d     = StBusy;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                    end
                end
                default: begin
                    state_d     = StEmpty;
                    main_ctrl_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_SKID_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

    // Saturating counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (o_valid && !i_ready && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (flush && (state_q != StEmpty) && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table plus a random FIFO check.
// Define PIPE_STAGE_SKID_STATS_EN to also exercise the statistics counters.
module tb_pipe_stage_skid_reg;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned CTRL_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              i_valid;
    logic              o_ready;
    logic [DATA_W-1:0] i_data;
    logic [CTRL_W-1:0] i_ctrl;
    logic              o_valid;
    logic              i_ready;
    logic [DATA_W-1:0] o_data;
    logic [CTRL_W-1:0] o_ctrl;
`ifdef PIPE_STAGE_SKID_STATS_EN
    logic [15:0]       o_stall_cnt;
    logic [15:0]       o_flush_cnt;
`endif

    pipe_stage_skid_reg #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_ctrl     (i_ctrl),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_ctrl     (o_ctrl)
`ifdef PIPE_STAGE_SKID_STATS_EN
        ,
        .o_stall_cnt(o_stall_cnt),
        .o_flush_cnt(o_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rst_n;
        logic              fl;
        logic              vld;
        logic              rdy;
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
        logic              e_valid;
        logic              e_ready;
        logic [DATA_W-1:0] e_data;
        logic [CTRL_W-1:0] e_ctrl;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    int passed = 0;
    int total  = 0;

    vec_t   vecs[$];
    entry_t model_q[$];

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst_n, input logic fl, input logic vld,
                                input logic rdy, input logic [DATA_W-1:0] data,
                                input logic [CTRL_W-1:0] ctrl, input logic e_valid,
                                input logic e_ready, input logic [DATA_W-1:0] e_data,
                                input logic [CTRL_W-1:0] e_ctrl);
        vec_t v;
        v.rst_n   = rst_n;
        v.fl      = fl;
        v.vld     = vld;
        v.rdy     = rdy;
        v.data    = data;
        v.ctrl    = ctrl;
        v.e_valid = e_valid;
        v.e_ready = e_ready;
        v.e_data  = e_data;
        v.e_ctrl  = e_ctrl;
        return v;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b0;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        i_ctrl  = '0;

        // Reset held two cycles with valid input present.
        vecs.push_back(mk(0, 0, 1, 1, 'h99, 'h5A, 0, 1, 'h0, 'h0));
        vecs.push_back(mk(0, 0, 1, 1, 'h99, 'h5A, 0, 1, 'h0, 'h0));
        // Full-throughput stream 1..8.
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(1, 0, 1, 1, DATA_W'(i), 'h00A5, 1, 1, DATA_W'(i), 'h00A5));
        end
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 0, 1, 'h8, 'h0));
        // Stall: A then B fills the skid, then drain.
        vecs.push_back(mk(1, 0, 1, 0, 'h11, 'h33, 1, 1, 'h11, 'h33));
        vecs.push_back(mk(1, 0, 1, 0, 'h22, 'h44, 1, 0, 'h11, 'h33));
        vecs.push_back(mk(1, 0, 1, 0, 'h23, 'h45, 1, 0, 'h11, 'h33));
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 1, 1, 'h22, 'h44));
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 0, 1, 'h22, 'h0));
        // Flush from FULL with a valid input in the flush cycle.
        vecs.push_back(mk(1, 0, 1, 0, 'h55, 'hFFFF, 1, 1, 'h55, 'hFFFF));
        vecs.push_back(mk(1, 0, 1, 0, 'h66, 'hFFFF, 1, 0, 'h55, 'hFFFF));
        vecs.push_back(mk(1, 1, 1, 0, 'h77, 'hFFFF, 0, 1, 'h55, 'h0));
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 0, 1, 'h55, 'h0));
        vecs.push_back(mk(1, 0, 1, 1, 'h88, 'h0F, 1, 1, 'h88, 'h0F));
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 0, 1, 'h88, 'h0));
        // Flush from BUSY while the entry is emitted.
        vecs.push_back(mk(1, 0, 1, 0, 'h90, 'h7, 1, 1, 'h90, 'h7));
        vecs.push_back(mk(1, 1, 1, 1, 'h91, 'h8, 0, 1, 'h90, 'h0));
        // Reset mid-operation (with flush also high) discards both entries.
        vecs.push_back(mk(1, 0, 1, 0, 'hAA, 'h1, 1, 1, 'hAA, 'h1));
        vecs.push_back(mk(1, 0, 1, 0, 'hBB, 'h2, 1, 0, 'hAA, 'h1));
        vecs.push_back(mk(0, 1, 1, 0, 'hCC, 'h3, 0, 1, 'h0, 'h0));
        vecs.push_back(mk(1, 0, 0, 1, 'h0, 'h0, 0, 1, 'h0, 'h0));

        #1;
        foreach (vecs[i]) begin
            reset   = vecs[i].rst_n;
            flush   = vecs[i].fl;
            i_valid = vecs[i].vld;
            i_ready = vecs[i].rdy;
            i_data  = vecs[i].data;
            i_ctrl  = vecs[i].ctrl;
            tick();
            check($sformatf("vec%0d o_valid", i), DATA_W'(o_valid), DATA_W'(vecs[i].e_valid));
            check($sformatf("vec%0d o_ready", i), DATA_W'(o_ready), DATA_W'(vecs[i].e_ready));
            check($sformatf("vec%0d o_data", i), o_data, vecs[i].e_data);
            check($sformatf("vec%0d o_ctrl", i), DATA_W'(o_ctrl), DATA_W'(vecs[i].e_ctrl));
        end

        // Random traffic against a FIFO reference model.
        reset = 1'b1;
        flush = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_data  = {$urandom, $urandom, $urandom, 32'(c)};
            i_ctrl  = CTRL_W'($urandom_range(1, 16'hFFFF));
            #1;
            check("rnd o_valid", DATA_W'(o_valid), DATA_W'(model_q.size() != 0));
            check("rnd o_ready", DATA_W'(o_ready), DATA_W'(model_q.size() < 2));
            if (!o_valid) begin
                check("rnd bubble ctrl", DATA_W'(o_ctrl), '0);
            end
            if (o_valid && i_ready && model_q.size() != 0) begin
                check("rnd o_data", o_data, model_q[0].data);
                check("rnd o_ctrl", DATA_W'(o_ctrl), DATA_W'(model_q[0].ctrl));
                void'(model_q.pop_front());
            end
            if (i_valid && o_ready) begin
                entry_t e;
                e.data = i_data;
                e.ctrl = i_ctrl;
                model_q.push_back(e);
            end
            tick();
        end

`ifdef PIPE_STAGE_SKID_STATS_EN
        reset   = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        tick();
        check("stats reset stall", DATA_W'(o_stall_cnt), '0);
        check("stats reset flush", DATA_W'(o_flush_cnt), '0);
        reset   = 1'b1;
        i_valid = 1'b1;
        i_data  = 'h5;
        i_ctrl  = 'h1;
        tick();
        i_valid = 1'b0;
        repeat (5) tick();
        flush   = 1'b1;
        i_ready = 1'b1;
        tick();
        flush   = 1'b0;
        check("stats stall_cnt", DATA_W'(o_stall_cnt), DATA_W'(5));
        check("stats flush_cnt", DATA_W'(o_flush_cnt), DATA_W'(1));
        // Flush of an empty stage does not count.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("stats flush_cnt empty", DATA_W'(o_flush_cnt), DATA_W'(1));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
